conv_fir_mac: RTL and testbench

- Parametrised successor to the two-tap difference convolver: a TAPS-deep, programmable-coefficient FIR convolution engine with a time-multiplexed single multiply-accumulate.
- Sits between the sample source and downstream arithmetic.
- Uses valid/ready handshakes on both sides, a saturating output of selectable width, and a history-clear control.
- Reset coefficients reproduce the legacy y[n] = x[n] - x[n-1] behaviour.

---
 rtl/conv_fir_mac.sv | 156 +++++++++++++++
 tb/tb_conv_fir_mac.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_fir_mac.sv
`default_nettype none
// ============================================================================
// Module   : conv_fir_mac
// Purpose  : TAPS-deep programmable FIR with one time-multiplexed MAC,
//            valid/ready on both sides and a saturated output.
// Revision : 1.0
// ============================================================================
module conv_fir_mac #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int TAPS   = 8,
    parameter int OUT_W  = 9,
    parameter int ACC_W  = DATA_W + COEF_W + $clog2(TAPS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_data,
    input  logic                     coef_we,
    input  logic [$clog2(TAPS)-1:0]  coef_addr,
    input  logic signed [COEF_W-1:0] coef_wdata,
    input  logic                     clr_hist,
    output logic                     busy
);
    localparam int c_AW = $clog2(TAPS);
    localparam int c_KW = c_AW + 1;
    localparam int c_PW = DATA_W + COEF_W;
    localparam logic [c_KW-1:0] c_LAST = c_KW'(TAPS);

    typedef enum logic [2:0] {
        S_IDLE = 3'b001,
        S_MAC  = 3'b010,
        S_OUT  = 3'b100
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic signed [DATA_W-1:0] r_hist [TAPS];
    logic signed [COEF_W-1:0] r_coef [TAPS];
    logic signed [ACC_W-1:0]  r_acc;
    logic [c_KW-1:0]          r_k;
    logic signed [OUT_W-1:0]  r_out;
    logic                     w_tap_ok;
    logic                     w_addr_ok;
    logic [c_AW-1:0]          w_tap;
    logic signed [c_PW-1:0]   w_prod;
    logic signed [ACC_W-1:0]  w_prod_ext;
    logic signed [OUT_W-1:0]  w_sat;

    // r_k runs one past the last tap; that extra MAC cycle loads the result
    assign w_tap_ok   = (r_k < c_LAST);
    assign w_tap      = w_tap_ok ? r_k[c_AW-1:0] : '0;
    assign w_prod     = r_coef[w_tap] * r_hist[w_tap];
    assign w_prod_ext = {{(ACC_W-c_PW){w_prod[c_PW-1]}}, w_prod};
    assign out_data   = r_out;

    if ((1 << c_AW) == TAPS) begin : g_addr_full
        assign w_addr_ok = 1'b1;
    end else begin : g_addr_chk
        assign w_addr_ok = ({1'b0, coef_addr} < c_LAST);
    end

    if (OUT_W >= ACC_W) begin : g_sat_ext
        assign w_sat = OUT_W'(r_acc);
    end else begin : g_sat_clamp
        logic [ACC_W-OUT_W:0] w_hi;
        assign w_hi = r_acc[ACC_W-1:OUT_W-1];
        always_comb begin
            if ((&w_hi) || !(|w_hi))
                w_sat = r_acc[OUT_W-1:0];
            else if (r_acc[ACC_W-1])
                w_sat = {1'b1, {(OUT_W-1){1'b0}}};
            else
                w_sat = {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b1;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid)
                    w_state_nxt = S_MAC;
            end
            S_MAC: begin
                if (!w_tap_ok)
                    w_state_nxt = S_OUT;
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < TAPS; i++) begin
                r_hist[i] <= '0;
                r_coef[i] <= '0;
            end
            r_coef[0] <= COEF_W'(1);
            r_coef[1] <= '1;
            r_acc     <= '0;
            r_k       <= '0;
            r_out     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (coef_we && w_addr_ok)
                        r_coef[coef_addr] <= coef_wdata;
                    // a clear coincident with a sample lets it enter a zeroed history
                    if (in_valid) begin
                        r_hist[0] <= in_data;
                        for (int i = 1; i < TAPS; i++)
                            r_hist[i] <= clr_hist ? '0 : r_hist[i-1];
                        r_acc <= '0;
                        r_k   <= '0;
                    end else if (clr_hist) begin
                        for (int i = 0; i < TAPS; i++)
                            r_hist[i] <= '0;
                    end
                end
                S_MAC: begin
                    if (w_tap_ok) begin
                        r_acc <= r_acc + w_prod_ext;
                        r_k   <= r_k + c_KW'(1);
                    end else begin
                        r_out <= w_sat;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_fir_mac.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_fir_mac
// Purpose  : Self-checking bench for conv_fir_mac against an arithmetic model.
// Revision : 1.0
// ============================================================================
module tb_conv_fir_mac;
    localparam int DATA_W = 8;
    localparam int COEF_W = 8;
    localparam int TAPS   = 8;
    localparam int OUT_W  = 9;
    localparam int c_YMAX = 2**(OUT_W-1) - 1;
    localparam int c_YMIN = -(2**(OUT_W-1));

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [OUT_W-1:0]  out_data;
    logic                     coef_we;
    logic [2:0]               coef_addr;
    logic signed [COEF_W-1:0] coef_wdata;
    logic                     clr_hist;
    logic                     busy;

    always #5 clk = ~clk;

    conv_fir_mac #(
        .DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .OUT_W(OUT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
        .clr_hist(clr_hist), .busy(busy)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int m_hist [TAPS];
    int m_coef [TAPS];

    typedef struct {
        int x;
        int y;
    } vec_t;
    vec_t vecs [8];

    task automatic check(input string name, input integer act, input integer exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out waiting on DUT, got 0, expected 1", name);
    endtask

    function automatic int model_y();
        int s = 0;
        for (int k = 0; k < TAPS; k++)
            s += m_coef[k] * m_hist[k];
        if (s > c_YMAX) s = c_YMAX;
        if (s < c_YMIN) s = c_YMIN;
        return s;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < TAPS; k++) begin
            m_hist[k] = 0;
            m_coef[k] = 0;
        end
        m_coef[0] = 1;
        m_coef[1] = -1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int x, input bit clr);
        int n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        if (!in_ready) timeout_fail("push_ready");
        in_valid = 1'b1;
        in_data  = x[DATA_W-1:0];
        clr_hist = clr;
        tick();
        in_valid = 1'b0;
        clr_hist = 1'b0;
        if (clr)
            for (int k = 0; k < TAPS; k++) m_hist[k] = 0;
        for (int k = TAPS-1; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = x;
    endtask

    task automatic wait_out(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 100) begin
            tick();
            cycles++;
        end
        if (!out_valid) timeout_fail("wait_out_valid");
    endtask

    task automatic get(output integer y, input int hold);
        int c;
        wait_out(c);
        repeat (hold) tick();
        y = out_data;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic wr_coef(input int addr, input int val);
        coef_we    = 1'b1;
        coef_addr  = addr[2:0];
        coef_wdata = val[COEF_W-1:0];
        tick();
        coef_we = 1'b0;
        m_coef[addr] = val;
    endtask

    task automatic sample(input string name, input int x, input int exp_y);
        integer y;
        push(x, 1'b0);
        get(y, 0);
        check(name, y, exp_y);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        integer y;
        int     lat;
        integer held;
        reset = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        coef_we = 1'b0; coef_addr = '0; coef_wdata = '0; clr_hist = 1'b0;
        repeat (3) tick();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_data", out_data, 0);
        reset = 1'b1;
        model_reset();

        // legacy difference behaviour with reset coefficients
        vecs = '{'{10, 10}, '{3, -7}, '{127, 124}, '{-128, -255},
                 '{0, 128}, '{-1, -1}, '{100, 101}, '{-100, -200}};
        for (int i = 0; i < 8; i++) begin
            push(vecs[i].x, 1'b0);
            if (i == 0) begin
                wait_out(lat);
                check("latency", lat, 9);
            end
            get(y, 0);
            check($sformatf("table_%0d", i), y, vecs[i].y);
        end

        // backpressure: result held while a new sample is offered
        push(5, 1'b0);
        wait_out(lat);
        held = model_y();
        in_valid = 1'b1;
        in_data  = 8'sd9;
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_data", out_data, held);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_valid_drop", out_valid, 0);
        check("bp_idle_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        for (int k = TAPS-1; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = 9;
        check("bp_accept_busy", busy, 1);
        get(y, 0);
        check("bp_next_result", y, model_y());

        // saturation with all-ones coefficients
        for (int k = 0; k < TAPS; k++) wr_coef(k, 1);
        for (int i = 0; i < 8; i++) begin
            push(100, 1'b0);
            get(y, i % 3);
            check("sat_pos_model", y, model_y());
            if (i == 7) check("sat_pos_255", y, 255);
        end
        for (int i = 0; i < 8; i++) begin
            push(-128, 1'b0);
            get(y, 0);
            check("sat_neg_model", y, model_y());
            if (i == 7) check("sat_neg_m256", y, -256);
        end

        // coefficient write during MAC is dropped, in IDLE it sticks
        for (int k = 0; k < TAPS; k++) wr_coef(k, (k == 0) ? 1 : (k == 1) ? -1 : 0);
        push(10, 1'b0);
        coef_we = 1'b1; coef_addr = 3'd0; coef_wdata = 8'sd5;
        tick();
        coef_we = 1'b0;
        get(y, 0);
        check("coef_mac_ignored", y, 138);
        wr_coef(0, 5);
        sample("coef_idle_applied", 20, 90);
        wr_coef(0, 1);

        // history clear
        sample("clr_pre_50", 50, 30);
        sample("clr_pre_40", 40, -10);
        clr_hist = 1'b1;
        tick();
        clr_hist = 1'b0;
        for (int k = 0; k < TAPS; k++) m_hist[k] = 0;
        sample("clr_after", 7, 7);
        push(-3, 1'b1);
        get(y, 0);
        check("clr_with_sample", y, -3);

        // reset in the third MAC cycle
        wr_coef(2, 4);
        push(33, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        model_reset();
        sample("midrst_next", 20, 20);

        // randomized traffic against the model
        for (int i = 0; i < 40; i++) begin
            bit clr;
            if ($urandom_range(0, 3) == 0)
                wr_coef($urandom_range(0, TAPS-1), $urandom_range(0, 255) - 128);
            clr = ($urandom_range(0, 7) == 0);
            push($urandom_range(0, 255) - 128, clr);
            get(y, $urandom_range(0, 3));
            check($sformatf("rand_%0d", i), y, model_y());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
